// File: rtl/modport_top.sv
// Streaming int8 MAC core: loads a weight bank, accumulates lane-wise products, emits requantized words.
// Optional build macro MODPORT_TOP_RELU_EN clamps negative lane results to zero before saturation.
module modport_top #(
  parameter int unsigned MEM_BW  = 32,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned NUM_W   = 4,
  parameter int unsigned NUM_OUT = 8,
  parameter int unsigned ACC_W   = 24,
  parameter int unsigned SHIFT   = 4
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              start,
  output logic              running,
  input  logic [MEM_BW-1:0] weights_input,
  input  logic              weights_valid,
  output logic              weights_ready,
  input  logic [MEM_BW-1:0] activations_input,
  input  logic              activations_valid,
  output logic              activations_ready,
  output logic [MEM_BW-1:0] output_data,
  output logic              output_valid
);

  localparam int unsigned LANES  = MEM_BW / DATA_W;
  localparam int unsigned WCNT_W = (NUM_W > 1) ? $clog2(NUM_W) : 1;
  localparam int unsigned OCNT_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2 ** (DATA_W - 1)));

  typedef enum logic [1:0] {S_IDLE, S_LOAD_W, S_COMPUTE} state_t;

  state_t                  r_state, w_state_nxt;
  logic [WCNT_W-1:0]       r_wcnt, w_wcnt_nxt;
  logic [WCNT_W-1:0]       r_acnt, w_acnt_nxt;
  logic [OCNT_W-1:0]       r_ocnt, w_ocnt_nxt;
  logic [MEM_BW-1:0]       r_bank [NUM_W];
  logic signed [ACC_W-1:0] r_acc  [LANES];
  logic signed [ACC_W-1:0] w_prod [LANES];
  logic signed [ACC_W-1:0] w_sum  [LANES];
  logic signed [ACC_W-1:0] w_shift[LANES];
  logic signed [ACC_W-1:0] w_clip [LANES];
  logic [MEM_BW-1:0]       w_result;
  logic                    r_running, r_weights_ready, r_act_ready, r_out_valid;
  logic [MEM_BW-1:0]       r_out_data;
  logic                    w_w_hs, w_a_hs, w_grp_end, w_run_end;

  assign running           = r_running;
  assign weights_ready     = r_weights_ready;
  assign activations_ready = r_act_ready;
  assign output_valid      = r_out_valid;
  assign output_data       = r_out_data;

  assign w_w_hs    = weights_valid && r_weights_ready;
  assign w_a_hs    = activations_valid && r_act_ready;
  assign w_grp_end = w_a_hs && (r_acnt == WCNT_W'(NUM_W - 1));
  assign w_run_end = w_grp_end && (r_ocnt == OCNT_W'(NUM_OUT - 1));

  // Lane datapath: sign-extended product, running sum, shift, optional ReLU, saturate
  always_comb begin
    w_prod   = '{default: '0};
    w_sum    = '{default: '0};
    w_shift  = '{default: '0};
    w_clip   = '{default: '0};
    w_result = '0;
    for (int l = 0; l < LANES; l++) begin
      w_prod[l]  = ACC_W'($signed(activations_input[l*DATA_W +: DATA_W]))
                 * ACC_W'($signed(r_bank[r_acnt][l*DATA_W +: DATA_W]));
      w_sum[l]   = r_acc[l] + w_prod[l];
      w_shift[l] = w_sum[l] >>> SHIFT;
`ifdef MODPORT_TOP_RELU_EN
      w_clip[l]  = w_shift[l][ACC_W-1] ? '0 : w_shift[l];
`else
      w_clip[l]  = w_shift[l];
`endif
      if (w_clip[l] > SAT_MAX)
        w_result[l*DATA_W +: DATA_W] = DATA_W'(SAT_MAX);
      else if (w_clip[l] < SAT_MIN)
        w_result[l*DATA_W +: DATA_W] = DATA_W'(SAT_MIN);
      else
        w_result[l*DATA_W +: DATA_W] = DATA_W'(w_clip[l]);
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state <= S_IDLE;
      r_wcnt  <= '0;
      r_acnt  <= '0;
      r_ocnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
      r_acnt  <= w_acnt_nxt;
      r_ocnt  <= w_ocnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    w_acnt_nxt  = r_acnt;
    w_ocnt_nxt  = r_ocnt;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_LOAD_W;
          w_wcnt_nxt  = '0;
          w_acnt_nxt  = '0;
          w_ocnt_nxt  = '0;
        end
      end
      S_LOAD_W: begin
        if (w_w_hs) begin
          if (r_wcnt == WCNT_W'(NUM_W - 1)) begin
            w_wcnt_nxt  = '0;
            w_state_nxt = S_COMPUTE;
          end else begin
            w_wcnt_nxt  = r_wcnt + WCNT_W'(1);
          end
        end
      end
      S_COMPUTE: begin
        if (w_grp_end) begin
          w_acnt_nxt = '0;
          if (w_run_end) begin
            w_ocnt_nxt  = '0;
            w_state_nxt = S_IDLE;
          end else begin
            w_ocnt_nxt  = r_ocnt + OCNT_W'(1);
          end
        end else if (w_a_hs) begin
          w_acnt_nxt = r_acnt + WCNT_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Readies and running follow the upcoming state so they line up with it after the edge
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_running       <= 1'b0;
      r_weights_ready <= 1'b0;
      r_act_ready     <= 1'b0;
      r_out_valid     <= 1'b0;
      r_out_data      <= '0;
      for (int k = 0; k < NUM_W; k++) r_bank[k] <= '0;
      for (int l = 0; l < LANES; l++) r_acc[l] <= '0;
    end else begin
      r_running       <= (w_state_nxt != S_IDLE);
      r_weights_ready <= (w_state_nxt == S_LOAD_W);
      r_act_ready     <= (w_state_nxt == S_COMPUTE);
      r_out_valid     <= w_grp_end;
      if (w_grp_end) r_out_data <= w_result;
      if (w_w_hs) r_bank[r_wcnt] <= weights_input;
      if (w_a_hs) begin
        for (int l = 0; l < LANES; l++) r_acc[l] <= w_grp_end ? '0 : w_sum[l];
      end
    end
  end

endmodule

// File: tb/tb_modport_top.sv
// Scoreboard bench for modport_top: expected words queued at stimulus time, popped on output pulses.
module tb_modport_top;

  localparam int unsigned MEM_BW  = 32;
  localparam int unsigned NUM_W   = 4;
  localparam int unsigned NUM_OUT = 8;
  localparam int unsigned N_ACT   = NUM_W * NUM_OUT;

  logic              clk = 1'b0;
  logic              arst_n = 1'b0;
  logic              start = 1'b0;
  logic              running;
  logic [MEM_BW-1:0] weights_input = '0;
  logic              weights_valid = 1'b0;
  logic              weights_ready;
  logic [MEM_BW-1:0] activations_input = '0;
  logic              activations_valid = 1'b0;
  logic              activations_ready;
  logic [MEM_BW-1:0] output_data;
  logic              output_valid;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] tb_w [NUM_W];
  logic [31:0] tb_a [N_ACT];
  logic [31:0] exp_q [$];
  bit          tb_abort = 1'b0;

  always #5 clk = ~clk;

  modport_top dut (
    .clk               (clk),
    .arst_n            (arst_n),
    .start             (start),
    .running           (running),
    .weights_input     (weights_input),
    .weights_valid     (weights_valid),
    .weights_ready     (weights_ready),
    .activations_input (activations_input),
    .activations_valid (activations_valid),
    .activations_ready (activations_ready),
    .output_data       (output_data),
    .output_valid      (output_valid)
  );

  // Reference: per-lane dot product over one group, >>>4, optional ReLU, clamp to int8
  function automatic logic [31:0] model_group(input logic [31:0] w [NUM_W], input logic [31:0] a [NUM_W]);
    logic [31:0] r;
    int s;
    logic [7:0] av, wv;
    r = '0;
    for (int l = 0; l < 4; l++) begin
      s = 0;
      for (int j = 0; j < NUM_W; j++) begin
        av = a[j][l*8 +: 8];
        wv = w[j][l*8 +: 8];
        s += int'($signed(av)) * int'($signed(wv));
      end
      s = s >>> 4;
`ifdef MODPORT_TOP_RELU_EN
      if (s < 0) s = 0;
`endif
      if (s > 127) s = 127;
      if (s < -128) s = -128;
      r[l*8 +: 8] = 8'(s);
    end
    return r;
  endfunction

  task automatic drive_run(input int gap_pct, input bit poke_start);
    int k;
    int guard;
    bit hs;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    k = 0; guard = 0;
    while (k < NUM_W && !tb_abort && guard < 2000) begin
      guard++;
      if ($urandom_range(99) < gap_pct) weights_valid = 1'b0;
      else begin weights_valid = 1'b1; weights_input = tb_w[k]; end
      if (poke_start) start = 1'($urandom_range(1));
      hs = weights_valid && weights_ready;
      @(negedge clk);
      if (hs) k++;
    end
    weights_valid = 1'b0;
    k = 0;
    while (k < N_ACT && !tb_abort && guard < 4000) begin
      guard++;
      if ($urandom_range(99) < gap_pct) activations_valid = 1'b0;
      else begin activations_valid = 1'b1; activations_input = tb_a[k]; end
      if (poke_start) start = 1'($urandom_range(1));
      hs = activations_valid && activations_ready;
      @(negedge clk);
      if (hs) k++;
    end
    activations_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_reset();
    arst_n = 1'b0;
    #1;
    n_tests++;
    if ({running, weights_ready, activations_ready, output_valid} !== 4'b0) begin
      n_fail++; $display("FAIL reset_ctrl got %b want 0000", {running, weights_ready, activations_ready, output_valid});
    end
    n_tests++;
    if (output_data !== 32'h0) begin n_fail++; $display("FAIL reset_data got %h want 00000000", output_data); end
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({running, weights_ready, activations_ready} !== 3'b0) begin
      n_fail++; $display("FAIL idle_hold got %b want 000", {running, weights_ready, activations_ready});
    end
  endtask

  task automatic test_datapath();
    logic [31:0] cw [5] = '{32'h01010101, 32'h7F7F7F7F, 32'h7F7F7F7F, 32'hFFFFFFFF, 32'h01010101};
    logic [31:0] ca [5] = '{32'h10101010, 32'h7F7F7F7F, 32'h80808080, 32'h10101010, 32'h10101010};
`ifdef MODPORT_TOP_RELU_EN
    logic [31:0] ce [5] = '{32'h04040404, 32'h7F7F7F7F, 32'h00000000, 32'h00000000, 32'h04040404};
`else
    logic [31:0] ce [5] = '{32'h04040404, 32'h7F7F7F7F, 32'h80808080, 32'hFCFCFCFC, 32'h04040404};
`endif
    int seen;
    int extra;
    logic [31:0] e;
    for (int c = 0; c < 5; c++) begin
      for (int k = 0; k < NUM_W; k++) tb_w[k] = cw[c];
      for (int k = 0; k < N_ACT; k++) tb_a[k] = ca[c];
      exp_q.delete();
      for (int g = 0; g < NUM_OUT; g++) exp_q.push_back(ce[c]);
      // last case adds valid gaps and start pokes to the ones pattern
      seen = 0; e = '0;
      fork
        drive_run((c == 4) ? 40 : 0, c == 4);
        begin
          for (int t = 0; t < 4000 && seen < NUM_OUT; t++) begin
            @(negedge clk);
            if (output_valid === 1'b1) begin
              e = exp_q.pop_front(); seen++;
              n_tests++;
              if (output_data !== e) begin
                n_fail++; $display("FAIL case%0d_out%0d got %h want %h", c, seen, output_data, e);
              end
            end
          end
          n_tests++;
          if (seen != NUM_OUT) begin n_fail++; $display("FAIL case%0d_pulses got %0d want %0d", c, seen, NUM_OUT); end
          n_tests++;
          if ({running, activations_ready} !== 2'b00) begin
            n_fail++; $display("FAIL case%0d_end got %b want 00", c, {running, activations_ready});
          end
        end
      join
      extra = 0;
      repeat (20) begin @(negedge clk); if (output_valid === 1'b1) extra++; end
      n_tests++;
      if (extra != 0 || running !== 1'b0) begin
        n_fail++; $display("FAIL case%0d_quiet got %0d extra running=%b want 0 0", c, extra, running);
      end
      n_tests++;
      if (output_data !== e) begin n_fail++; $display("FAIL case%0d_hold got %h want %h", c, output_data, e); end
    end
  endtask

  task automatic test_stalls();
    logic [31:0] gb [NUM_W];
    int seen;
    int extra;
    logic [31:0] e;
    for (int k = 0; k < NUM_W; k++) tb_w[k] = $urandom;
    for (int k = 0; k < N_ACT; k++) tb_a[k] = $urandom;
    exp_q.delete();
    for (int g = 0; g < NUM_OUT; g++) begin
      for (int j = 0; j < NUM_W; j++) gb[j] = tb_a[g*NUM_W + j];
      exp_q.push_back(model_group(tb_w, gb));
    end
    seen = 0;
    fork
      drive_run(30, 1'b1);
      begin
        for (int t = 0; t < 4000 && seen < NUM_OUT; t++) begin
          @(negedge clk);
          if (output_valid === 1'b1) begin
            e = exp_q.pop_front(); seen++;
            n_tests++;
            if (output_data !== e) begin
              n_fail++; $display("FAIL rand_out%0d got %h want %h", seen, output_data, e);
            end
          end
        end
        n_tests++;
        if (seen != NUM_OUT) begin n_fail++; $display("FAIL rand_pulses got %0d want %0d", seen, NUM_OUT); end
      end
    join
    extra = 0;
    repeat (20) begin @(negedge clk); if (output_valid === 1'b1) extra++; end
    n_tests++;
    if (extra != 0 || running !== 1'b0) begin
      n_fail++; $display("FAIL rand_quiet got %0d extra running=%b want 0 0", extra, running);
    end
  endtask

  task automatic test_reset_midrun();
    int seen;
    logic [31:0] e;
    for (int k = 0; k < NUM_W; k++) tb_w[k] = 32'h01010101;
    for (int k = 0; k < N_ACT; k++) tb_a[k] = 32'h10101010;
    exp_q.delete();
    for (int g = 0; g < NUM_OUT; g++) exp_q.push_back(32'h04040404);
    tb_abort = 1'b0;
    seen = 0;
    fork
      drive_run(0, 1'b0);
      begin
        for (int t = 0; t < 2000 && seen < 2; t++) begin
          @(negedge clk);
          if (output_valid === 1'b1) begin
            e = exp_q.pop_front(); seen++;
            n_tests++;
            if (output_data !== e) begin n_fail++; $display("FAIL abort_out%0d got %h want %h", seen, output_data, e); end
          end
        end
        n_tests++;
        if (seen != 2) begin n_fail++; $display("FAIL abort_pulses got %0d want 2", seen); end
        @(posedge clk); #2;
        arst_n = 1'b0; tb_abort = 1'b1;
        #1;
        n_tests++;
        if ({running, weights_ready, activations_ready, output_valid} !== 4'b0) begin
          n_fail++; $display("FAIL abort_ctrl got %b want 0000", {running, weights_ready, activations_ready, output_valid});
        end
        n_tests++;
        if (output_data !== 32'h0) begin n_fail++; $display("FAIL abort_data got %h want 00000000", output_data); end
      end
    join
    exp_q.delete();
    repeat (3) @(negedge clk);
    arst_n = 1'b1;
    tb_abort = 1'b0;
    repeat (2) @(negedge clk);
    test_datapath();
  endtask

  initial begin
    test_reset();
    test_datapath();
    test_stalls();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
